// File: rtl/cla_adder_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cla_adder_arbiter
//
// Purpose:
//   Shares one external, decomposed CLA adder between two requesters. Grants
//   are round-robin and only one operation is in flight at a time. Accepted
//   operands are registered onto the adder inputs and held for LAT cycles.
//   The adder sum is then captured and returned together with the ID of the
//   requester that issued it.
//
// Parameters:
//   NBIT  operand width; the sum is NBIT+1 bits and its MSB is the carry out
//   LAT   cycles from operand launch to sampling add_s (1..15)
//
// Ports:
//   clk                      rising-edge clock
//   rst                      synchronous reset, active-high
//   req0_valid / req0_ready  requester 0 handshake (ready only in IDLE)
//   req0_a, req0_b, req0_cin requester 0 operands
//   req1_*                   same set for requester 1
//   add_a, add_b, add_cin    registered operands to the shared adder
//   add_s                    sum from the shared adder
//   res_valid / res_ready    result handshake
//   res_id                   requester that issued the result
//   res_sum                  captured sum
//   err                      sticky self-check error
//
// Optional feature:
//   CLA_ARB_CHECK_EN defined   -> at the capture edge, add_s is compared with a
//                                 behavioural sum. A mismatch sets err until rst.
//   CLA_ARB_CHECK_EN undefined -> no comparator is built and err is tied to 0.
// -----------------------------------------------------------------------------
module cla_adder_arbiter #(
  parameter int NBIT = 7,
  parameter int LAT  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [NBIT-1:0] req0_a,
  input  logic [NBIT-1:0] req0_b,
  input  logic            req0_cin,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [NBIT-1:0] req1_a,
  input  logic [NBIT-1:0] req1_b,
  input  logic            req1_cin,
  output logic [NBIT-1:0] add_a,
  output logic [NBIT-1:0] add_b,
  output logic            add_cin,
  input  logic [NBIT:0]   add_s,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            res_id,
  output logic [NBIT:0]   res_sum,
  output logic            err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [3:0] LAT_CNT = 4'(LAT);

  state_t          state_reg;
  logic [3:0]      cnt_reg;
  logic            prio_reg;
  logic            id_reg;
  logic [NBIT-1:0] add_a_reg;
  logic [NBIT-1:0] add_b_reg;
  logic            add_cin_reg;
  logic            res_valid_reg;
  logic            res_id_reg;
  logic [NBIT:0]   res_sum_reg;

  // Requester ports are gathered into indexed vectors so that the grant and
  // the operand mux do not need to be written out once per requester.
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [NBIT-1:0] req_a   [2];
  logic [NBIT-1:0] req_b   [2];
  logic [1:0]      req_cin;

  assign req_valid  = {req1_valid, req0_valid};
  assign req_a[0]   = req0_a;
  assign req_a[1]   = req1_a;
  assign req_b[0]   = req0_b;
  assign req_b[1]   = req1_b;
  assign req_cin    = {req1_cin, req0_cin};
  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];

  // When both requesters are valid, prio breaks the tie. Otherwise the single
  // valid requester wins. grant_id is only meaningful while grant_any is set.
  logic grant_any;
  logic grant_id;
  logic transfer;

  assign grant_any = |req_valid;
  assign grant_id  = (&req_valid) ? prio_reg : req_valid[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      // Ready is gated by rst so that no handshake can complete while the
      // block is being reset.
      assign req_ready[gi] = (state_reg == IDLE) && !rst && grant_any &&
                             (grant_id == 1'(gi));
    end
  endgenerate

  assign transfer = |(req_valid & req_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      prio_reg      <= 1'b0;
      id_reg        <= 1'b0;
      add_a_reg     <= '0;
      add_b_reg     <= '0;
      add_cin_reg   <= 1'b0;
      res_valid_reg <= 1'b0;
      res_id_reg    <= 1'b0;
      res_sum_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (transfer) begin
            add_a_reg   <= req_a[grant_id];
            add_b_reg   <= req_b[grant_id];
            add_cin_reg <= req_cin[grant_id];
            id_reg      <= grant_id;
            cnt_reg     <= LAT_CNT;
            prio_reg    <= ~grant_id;
            state_reg   <= WAIT;
          end
        end
        WAIT: begin
          // add_* are left untouched, so the adder sees stable operands
          // for the whole countdown.
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) begin
            res_sum_reg   <= add_s;
            res_id_reg    <= id_reg;
            res_valid_reg <= 1'b1;
            state_reg     <= HOLD;
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign add_a     = add_a_reg;
  assign add_b     = add_b_reg;
  assign add_cin   = add_cin_reg;
  assign res_valid = res_valid_reg;
  assign res_id    = res_id_reg;
  assign res_sum   = res_sum_reg;

`ifdef CLA_ARB_CHECK_EN
  // The reference sum uses the held operands. It is evaluated only on the
  // edge where add_s is captured, because add_s is not meaningful elsewhere.
  logic [NBIT:0] ref_sum;
  logic          err_reg;

  assign ref_sum = {1'b0, add_a_reg} + {1'b0, add_b_reg} +
                   {{NBIT{1'b0}}, add_cin_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if ((state_reg == WAIT) && (cnt_reg == 4'd1) && (add_s != ref_sum)) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cla_adder_arbiter.sv
`timescale 1ns/1ps
// Testbench for cla_adder_arbiter.
// Stimulus is directed and random. A predictor models the arbitration rules
// and pushes the expected result whenever a transfer occurs. A separate
// monitor pops and compares each result that the DUT presents.
module tb_cla_adder_arbiter;
  localparam int NBIT = 7;
  localparam int LAT  = 1;
`ifdef CLA_ARB_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            req0_valid, req0_ready, req0_cin;
  logic [NBIT-1:0] req0_a, req0_b;
  logic            req1_valid, req1_ready, req1_cin;
  logic [NBIT-1:0] req1_a, req1_b;
  logic [NBIT-1:0] add_a, add_b;
  logic            add_cin;
  logic [NBIT:0]   add_s;
  logic            res_valid, res_ready, res_id, err;
  logic [NBIT:0]   res_sum;

  always #5 clk = ~clk;

  cla_adder_arbiter #(.NBIT(NBIT), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_cin(req1_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_sum(res_sum), .err(err)
  );

  // Behavioural shared adder. bad_adder forces a wrong (zero) sum.
  logic bad_adder;
  always_comb begin
    add_s = {1'b0, add_a} + {1'b0, add_b} + {{NBIT{1'b0}}, add_cin};
    if (bad_adder) add_s = '0;
  end

  typedef struct {
    bit            id;
    logic [NBIT:0] sum;
    bit            bad;
    int            acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   acc_id_log[$];
  int   acc_cyc_log[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   m_busy = 1'b0;
  bit   m_prio = 1'b0;
  bit   err_exp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Predictor: applies the arbitration rules to the sampled inputs.
  always @(negedge clk) begin
    bit   e0, e1, gid;
    int   s;
    exp_t e;
    if (rst) begin
      chk("ready0_in_rst", 32'(req0_ready), 0);
      chk("ready1_in_rst", 32'(req1_ready), 0);
      sb.delete();
      m_busy  = 1'b0;
      m_prio  = 1'b0;
      err_exp = 1'b0;
    end else begin
      e0 = !m_busy && req0_valid && (!req1_valid || !m_prio);
      e1 = !m_busy && req1_valid && (!req0_valid ||  m_prio);
      chk("req0_ready", 32'(req0_ready), 32'(e0));
      chk("req1_ready", 32'(req1_ready), 32'(e1));
      if (e0 || e1) begin
        gid = e1;
        s = gid ? (int'(req1_a) + int'(req1_b) + int'(req1_cin))
                : (int'(req0_a) + int'(req0_b) + int'(req0_cin));
        e.id      = gid;
        e.sum     = bad_adder ? '0 : (NBIT+1)'(s);
        e.bad     = bad_adder;
        e.acc_cyc = cyc + 1;
        sb.push_back(e);
        acc_id_log.push_back(int'(gid));
        acc_cyc_log.push_back(cyc + 1);
        m_busy = 1'b1;
        m_prio = !gid;
        $display("accept  id=%0d expected_sum=%03h edge=%0d", gid, e.sum, cyc + 1);
      end else if (m_busy && res_valid && res_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  // Monitor: compares each presented result with the scoreboard head.
  always @(negedge clk) begin
    bit            prev_v;
    logic [NBIT:0] hold_sum;
    bit            hold_id;
    exp_t          e;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (res_valid && !prev_v) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got id=%0d sum=%03h expected none", res_id, res_sum);
        end else begin
          e = sb[0];
          chk("latency", 32'(cyc - e.acc_cyc), 32'(LAT));
          chk("res_id", 32'(res_id), 32'(e.id));
          chk("res_sum", 32'(res_sum), 32'(e.sum));
          if (e.bad && CHK_EN) err_exp = 1'b1;
          chk("err", 32'(err), 32'(err_exp));
        end
      end else if (res_valid && prev_v) begin
        chk("hold_sum_stable", 32'(res_sum), 32'(hold_sum));
        chk("hold_id_stable", 32'(res_id), 32'(hold_id));
      end else if (!res_valid && prev_v) begin
        chk("res_valid_held", 32'(res_valid), 1);
      end
      if (res_valid && res_ready && sb.size() > 0) begin
        $display("result  id=%0d sum=%03h edge=%0d", res_id, res_sum, cyc);
        void'(sb.pop_front());
      end
      prev_v   = res_valid && !res_ready;
      hold_sum = res_sum;
      hold_id  = res_id;
    end
  end

  // Called at posedge+1. Holds the request until it is accepted, then drops it.
  task automatic issue(input bit id, input logic [NBIT-1:0] a, input logic [NBIT-1:0] b,
                       input logic cin);
    int  n;
    bit  got;
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_cin = cin; end
    else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_cin = cin; end
    got = 0;
    for (n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      got = id ? req1_ready : req0_ready;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: requester %0d got no ready, required ready within 50 cycles", id);
    end
    @(posedge clk); #1;
    if (id) req1_valid = 0; else req0_valid = 0;
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 60 && (m_busy || sb.size() != 0); n++) begin
      @(posedge clk); #1;
    end
    if (m_busy || sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=%0d pending=%0d required idle", m_busy, sb.size());
    end
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    int n;
    rst = 1; bad_adder = 0; res_ready = 1;
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_cin = 0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_cin = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_id", 32'(res_id), 0);
    chk("rst_res_sum", 32'(res_sum), 0);
    chk("rst_add_a", 32'(add_a), 0);
    chk("rst_add_b", 32'(add_b), 0);
    chk("rst_add_cin", 32'(add_cin), 0);
    chk("rst_err", 32'(err), 0);
    rst = 0;

    // Directed operations with carry out set.
    issue(0, 7'h7F, 7'h01, 1'b0);
    wait_idle();
    issue(1, 7'h7F, 7'h7F, 1'b1);
    wait_idle();

    // Both valid continuously: grants alternate, LAT+2 cycles apart.
    do_reset();
    acc_id_log.delete();
    acc_cyc_log.delete();
    req0_valid = 1; req0_a = 7'h15; req0_b = 7'h2A; req0_cin = 1;
    req1_valid = 1; req1_a = 7'h40; req1_b = 7'h3F; req1_cin = 0;
    repeat (12) @(posedge clk);
    #1 req0_valid = 0; req1_valid = 0;
    wait_idle();
    chk("rr_count_ge4", 32'(acc_id_log.size() >= 4), 1);
    if (acc_id_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("rr_grant_order", 32'(acc_id_log[i]), 32'(i % 2));
      for (int i = 1; i < 4; i++)
        chk("rr_spacing", 32'(acc_cyc_log[i] - acc_cyc_log[i-1]), 32'(LAT + 2));
    end

    // Back-pressure in HOLD for 5 cycles while requester 1 waits.
    res_ready = 0;
    issue(0, 7'h33, 7'h44, 1'b1);
    for (n = 0; n < 20 && !res_valid; n++) @(negedge clk);
    chk("hold_reached", 32'(res_valid), 1);
    @(posedge clk); #1;
    req1_valid = 1; req1_a = 7'h01; req1_b = 7'h02; req1_cin = 0;
    repeat (5) @(posedge clk);
    #1 chk("hold_res_valid_after5", 32'(res_valid), 1);
    res_ready = 1;
    issue(1, 7'h01, 7'h02, 1'b0);
    wait_idle();

    // Reset during WAIT aborts the operation and clears prio.
    issue(0, 7'h11, 7'h22, 1'b0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("abort_res_valid", 32'(res_valid), 0);
    req1_valid = 1; req1_a = 7'h05; req1_b = 7'h06; req1_cin = 1;
    issue(0, 7'h07, 7'h08, 1'b0);
    issue(1, 7'h05, 7'h06, 1'b1);
    wait_idle();

    // Faulty adder: err is set only when the self-check is built.
    bad_adder = 1;
    issue(0, 7'h01, 7'h01, 1'b0);
    wait_idle();
    bad_adder = 0;
    chk("err_after_fault", 32'(err), 32'(CHK_EN));
    issue(1, 7'h10, 7'h20, 1'b0);
    wait_idle();
    chk("err_sticky", 32'(err), 32'(CHK_EN));
    do_reset();
    chk("err_cleared", 32'(err), 0);

    // Random traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = NBIT'($urandom); req0_b = NBIT'($urandom); req0_cin = 1'($urandom);
      req1_a = NBIT'($urandom); req1_b = NBIT'($urandom); req1_cin = 1'($urandom);
      res_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    req0_valid = 0; req1_valid = 0; res_ready = 1;
    wait_idle();
    chk("scoreboard_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
